// File: rtl/fnd_scan_controller.sv
// Multiplexed common-anode 7-segment scan controller with a sequential
// binary-to-BCD converter, leading-zero blanking, decimal points and overflow dashes.
module fnd_scan_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_WIDTH = 14,
  parameter int SCAN_DIV   = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_load,
  input  logic                  i_blank_lz,
  input  logic [NUM_DIGITS-1:0] i_dp,
  output logic                  o_busy,
  output logic                  o_overflow,
  output logic [NUM_DIGITS-1:0] o_digitSelect,
  output logic [7:0]            o_fndFont
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PS_W  = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  function automatic logic [39:0] pow10(input int unsigned n);
    logic [39:0] p;
    p = 40'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 40'd10;
    return p;
  endfunction

  localparam logic [39:0]           LIMIT   = pow10(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

  logic [PS_W-1:0]       prescaler;
  logic [IDX_W-1:0]      digit_idx;
  logic [CNT_W-1:0]      iter_cnt;
  logic [DATA_WIDTH-1:0] bin_reg;
  logic [BCD_W-1:0]      bcd_work;
  logic [BCD_W-1:0]      bcd_adj;
  logic [BCD_W-1:0]      bcd_next;
  logic [BCD_W-1:0]      display_bcd;
  logic                  ovf_pending;
  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  logic [7:0]            seg;
  logic [7:0]            font_next;

  // One shift-add-3 step; nibbles only carry upward, so truncating the top
  // of an overflowing value never corrupts the digits kept.
  always_comb begin
    bcd_adj = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_work[k*4 +: 4] >= 4'd5) bcd_adj[k*4 +: 4] = bcd_work[k*4 +: 4] + 4'd3;
      else                            bcd_adj[k*4 +: 4] = bcd_work[k*4 +: 4];
    end
    bcd_next = {bcd_adj[BCD_W-2:0], bin_reg[DATA_WIDTH-1]};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_busy      <= 1'b0;
      o_overflow  <= 1'b0;
      iter_cnt    <= '0;
      bin_reg     <= '0;
      bcd_work    <= '0;
      ovf_pending <= 1'b0;
      display_bcd <= '0;
    end else if (!o_busy) begin
      if (i_load) begin
        o_busy      <= 1'b1;
        bin_reg     <= i_data;
        bcd_work    <= '0;
        iter_cnt    <= CNT_W'(DATA_WIDTH);
        ovf_pending <= (40'(i_data) >= LIMIT);
      end
    end else begin
      bin_reg  <= bin_reg << 1;
      bcd_work <= bcd_next;
      iter_cnt <= iter_cnt - CNT_W'(1);
      if (iter_cnt == CNT_W'(1)) begin
        o_busy      <= 1'b0;
        display_bcd <= bcd_next;
        o_overflow  <= ovf_pending;
      end
    end
  end

  // Digit k blanks when it and every higher digit are zero; digit 0 never blanks.
  always_comb begin
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run     = zero_run && (display_bcd[k*4 +: 4] == 4'd0);
      blank_vec[k] = i_blank_lz && zero_run;
    end
  end

  always_comb begin
    cur_nib = display_bcd[int'(digit_idx)*4 +: 4];
    case (cur_nib)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hFF;
    endcase
    if (o_overflow)                font_next = 8'hBF;
    else if (blank_vec[digit_idx]) font_next = 8'hFF;
    else                           font_next = seg;
    if (i_dp[digit_idx]) font_next[7] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prescaler     <= '0;
      digit_idx     <= '0;
      o_digitSelect <= '1;
      o_fndFont     <= 8'hFF;
    end else begin
      o_digitSelect <= ~(SEL_ONE << digit_idx);
      o_fndFont     <= font_next;
      if (prescaler == PS_W'(SCAN_DIV - 1)) begin
        prescaler <= '0;
        if (digit_idx == IDX_W'(NUM_DIGITS - 1)) digit_idx <= '0;
        else                                     digit_idx <= digit_idx + IDX_W'(1);
      end else begin
        prescaler <= prescaler + PS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller: 4-digit/14-bit instance with fast scan,
// plus a 6-digit/20-bit instance for the wider parametrisation.
module tb_fnd_scan_controller;

  logic        clk;
  logic        rst;
  logic [13:0] data4;
  logic        load4;
  logic        blz4;
  logic [3:0]  dp4;
  logic        busy4, ovf4;
  logic [3:0]  sel4;
  logic [7:0]  font4;

  logic [19:0] data6;
  logic        load6;
  logic        busy6, ovf6;
  logic [5:0]  sel6;
  logic [7:0]  font6;

  int checks;
  int failures;
  int busy_n;
  logic [7:0] seen4 [4];
  logic [7:0] seen6 [6];

  fnd_scan_controller #(.NUM_DIGITS(4), .DATA_WIDTH(14), .SCAN_DIV(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_data(data4), .i_load(load4),
    .i_blank_lz(blz4), .i_dp(dp4), .o_busy(busy4), .o_overflow(ovf4),
    .o_digitSelect(sel4), .o_fndFont(font4)
  );

  fnd_scan_controller #(.NUM_DIGITS(6), .DATA_WIDTH(20), .SCAN_DIV(2)) dut6 (
    .i_clk(clk), .i_reset(rst), .i_data(data6), .i_load(load6),
    .i_blank_lz(1'b0), .i_dp(6'b0), .o_busy(busy6), .o_overflow(ovf6),
    .o_digitSelect(sel6), .o_fndFont(font6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] data;
    logic        blz;
    logic [3:0]  dp;
    logic [31:0] fonts;  // {d3,d2,d1,d0}
    logic        ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_load4(input logic [13:0] d);
    @(negedge clk);
    load4 = 1'b1;
    data4 = d;
    @(negedge clk);
    load4  = 1'b0;
    busy_n = 0;
    while (busy4 && busy_n < 100) begin
      busy_n++;
      @(negedge clk);
    end
  endtask

  task automatic read4();
    int bad;
    bad = 0;
    for (int k = 0; k < 4; k++) seen4[k] = 8'h00;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      case (sel4)
        4'b1110: seen4[0] = font4;
        4'b1101: seen4[1] = font4;
        4'b1011: seen4[2] = font4;
        4'b0111: seen4[3] = font4;
        default: bad++;
      endcase
    end
    check("onehot4", bad, 0);
  endtask

  task automatic read6();
    int bad;
    bad = 0;
    for (int k = 0; k < 6; k++) seen6[k] = 8'h00;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      bad++;
      for (int k = 0; k < 6; k++) begin
        if (sel6 == ~(6'b1 << k)) begin
          seen6[k] = font6;
          bad--;
        end
      end
    end
    check("onehot6", bad, 0);
  endtask

  initial begin
    int ok;
    checks   = 0;
    failures = 0;
    rst = 1'b1; load4 = 1'b0; data4 = '0; blz4 = 1'b0; dp4 = '0;
    load6 = 1'b0; data6 = '0;

    vecs[0] = '{14'd1234,  1'b0, 4'b0000, 32'hF9A4B099, 1'b0};
    vecs[1] = '{14'd7,     1'b1, 4'b0010, 32'hFFFF7FF8, 1'b0};
    vecs[2] = '{14'd7,     1'b0, 4'b0010, 32'hC0C040F8, 1'b0};
    vecs[3] = '{14'd10000, 1'b0, 4'b0000, 32'hBFBFBFBF, 1'b1};
    vecs[4] = '{14'd9999,  1'b0, 4'b0000, 32'h90909090, 1'b0};
    vecs[5] = '{14'd0,     1'b1, 4'b0000, 32'hFFFFFFC0, 1'b0};
    vecs[6] = '{14'd10000, 1'b1, 4'b0001, 32'hBFBFBF3F, 1'b1};
    vecs[7] = '{14'd1005,  1'b1, 4'b0000, 32'hF9C0C092, 1'b0};
    vecs[8] = '{14'd16383, 1'b0, 4'b0000, 32'hBFBFBFBF, 1'b1};
    vecs[9] = '{14'd50,    1'b1, 4'b0000, 32'hFFFF92C0, 1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_sel", sel4, 4'b1111);
    check("rst_font", font4, 8'hFF);
    check("rst_busy", busy4, 0);
    check("rst_ovf", ovf4, 0);
    rst = 1'b0;

    // Scan order: each digit held 4 clocks, digit 0 first after release
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sel4 !== ~(4'b1 << ((i / 4) % 4)) || font4 !== 8'hC0) ok = 0;
    end
    check("scan_seq", ok, 1);

    // Display holds old value throughout conversion
    @(negedge clk);
    load4 = 1'b1; data4 = 14'd1234;
    @(negedge clk);
    load4 = 1'b0;
    busy_n = 0; ok = 1;
    while (busy4 && busy_n < 100) begin
      if (font4 !== 8'hC0) ok = 0;
      busy_n++;
      @(negedge clk);
    end
    check("busy_len_1234", busy_n, 14);
    check("no_partial", ok, 1);

    for (int r = 0; r < 10; r++) begin
      do_load4(vecs[r].data);
      check($sformatf("row%0d_busy", r), busy_n, 14);
      blz4 = vecs[r].blz;
      dp4  = vecs[r].dp;
      read4();
      check($sformatf("row%0d_ovf", r), ovf4, vecs[r].ovf);
      for (int k = 0; k < 4; k++)
        check($sformatf("row%0d_d%0d", r, k), seen4[k], vecs[r].fonts[k*8 +: 8]);
    end
    blz4 = 1'b0; dp4 = '0;

    // Load during busy is dropped
    @(negedge clk);
    load4 = 1'b1; data4 = 14'd42;
    @(negedge clk);
    load4 = 1'b0;
    busy_n = 0;
    while (busy4 && busy_n < 100) begin
      busy_n++;
      if (busy_n == 5) begin load4 = 1'b1; data4 = 14'd99; end
      else load4 = 1'b0;
      @(negedge clk);
    end
    load4 = 1'b0;
    check("ign_busy_len", busy_n, 14);
    read4();
    check("ign_d0", seen4[0], 8'hA4);
    check("ign_d1", seen4[1], 8'h99);
    check("ign_d2", seen4[2], 8'hC0);
    check("ign_d3", seen4[3], 8'hC0);

    // Reset mid-conversion after an overflow
    do_load4(14'd10000);
    check("pre_rst_ovf", ovf4, 1);
    @(negedge clk);
    load4 = 1'b1; data4 = 14'd555;
    @(negedge clk);
    load4 = 1'b0;
    busy_n = 0;
    while (busy4 && busy_n < 100) begin
      busy_n++;
      if (busy_n == 7) rst = 1'b1;
      @(negedge clk);
    end
    check("mid_rst_cyc", busy_n, 7);
    check("mid_rst_busy", busy4, 0);
    check("mid_rst_ovf", ovf4, 0);
    check("mid_rst_sel", sel4, 4'b1111);
    check("mid_rst_font", font4, 8'hFF);
    rst = 1'b0;
    read4();
    for (int k = 0; k < 4; k++) check($sformatf("mid_rst_d%0d", k), seen4[k], 8'hC0);

    // Wider instance
    @(negedge clk);
    load6 = 1'b1; data6 = 20'd999999;
    @(negedge clk);
    load6 = 1'b0;
    busy_n = 0;
    while (busy6 && busy_n < 100) begin busy_n++; @(negedge clk); end
    check("w6_busy_len", busy_n, 20);
    read6();
    check("w6_ovf0", ovf6, 0);
    for (int k = 0; k < 6; k++) check($sformatf("w6_9_d%0d", k), seen6[k], 8'h90);

    @(negedge clk);
    load6 = 1'b1; data6 = 20'd1000000;
    @(negedge clk);
    load6 = 1'b0;
    busy_n = 0;
    while (busy6 && busy_n < 100) begin busy_n++; @(negedge clk); end
    check("w6_busy_len2", busy_n, 20);
    read6();
    check("w6_ovf1", ovf6, 1);
    for (int k = 0; k < 6; k++) check($sformatf("w6_dash_d%0d", k), seen6[k], 8'hBF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
- Parametrised multiplexed 7-segment (FND) display controller.
- Converts a binary value to BCD with a sequential shift-add-3 engine and drives the digits through a time-multiplexed scan.
- Adds configurable digit count, leading-zero blanking, per-digit decimal points, overflow indication and a load/busy handshake.
- Sits between the counter/MicroBlaze-visible data path and the board's common-anode FND pins.

Parameters:
NUM_DIGITS, 4, number of scanned digits (1..8)
DATA_WIDTH, 14, width of binary input value (1..27)
SCAN_DIV, 100000, i_clk cycles each digit stays selected (>=2)

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous, active-high reset
i_data  input  DATA_WIDTH  unsigned binary value to display
i_load  input  1  single-cycle request: capture i_data and convert
i_blank_lz  input  1  1 = blank leading zeros (level, sampled every scan step)
i_dp  input  NUM_DIGITS  decimal point enable per digit, bit0 = least significant digit
o_busy  output  1  conversion in progress
o_overflow  output  1  last accepted value exceeded 10^NUM_DIGITS-1
o_digitSelect  output  NUM_DIGITS  active-low digit enables, bit0 = least significant digit
o_fndFont  output  8  active-low segments {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset: i_clk and i_reset only; reset is synchronous and active-high. While i_reset=1 at a clock edge:
  - prescaler = 0, digit index = 0, conversion engine idle, display BCD register = 0.
  - o_busy = 0, o_overflow = 0.
  - o_digitSelect = all ones, o_fndFont = 8'hFF.
- Reset mid-conversion aborts it; the display register is not updated.
- Prescaler counts 0..SCAN_DIV-1 and wraps. On the wrap cycle the digit index advances; it wraps from NUM_DIGITS-1 to 0.
- Outputs are registered and reflect the current digit index one cycle after the index changes. The first edge after reset release drives digit 0.
- Exactly one o_digitSelect bit is low at any time outside reset.
- Handshake:
  - i_load is accepted when o_busy=0. i_data is captured and o_busy goes high on the next edge.
  - The engine performs DATA_WIDTH shift-add-3 iterations, one per cycle. o_busy stays high for exactly DATA_WIDTH cycles.
  - On the edge o_busy falls, the display BCD register and o_overflow update atomically.
  - i_load while o_busy=1 is ignored; no queueing.
  - The displayed value never shows partial conversion results.
- Overflow:
  - At capture, i_data >= 10^NUM_DIGITS sets a pending flag, applied at completion.
  - While o_overflow=1, every digit shows a dash (g only). The dash pattern ignores blanking but still honours the dp bits.
  - o_overflow clears on the next completed conversion of an in-range value.
- Font table (active-low, dp bit7=1 off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - dash=BF, blank=FF. Codes 10..15 (unreachable) = blank.
  - The dp bit7 is cleared when i_dp[index]=1, including on blanked digits.
- Leading-zero blanking:
  - With i_blank_lz=1, digit k is blanked if it and all higher digits are 0.
  - Digit 0 is never blanked, so value 0 shows "0".
  - Blanked digits keep their select asserted (low) with font FF, so scan timing is unchanged.
- Widths: BCD register is 4*NUM_DIGITS bits. The 10^NUM_DIGITS constant is computed at elaboration. Values below 2^DATA_WIDTH that fit are always exact.

Test Plan:
- Reset/scan (NUM_DIGITS=4, SCAN_DIV=4): assert i_reset 3 cycles -> o_digitSelect=4'b1111, o_fndFont=FF. Release -> o_digitSelect cycles 1110,1101,1011,0111,1110 every 4 clocks, all showing C0.
- Conversion latency: i_load with i_data=1234 -> o_busy high exactly 14 cycles. Digits 3..0 then show F9,A4,B0,99. The display is unchanged before o_busy falls.
- Blanking/dp: load 7, i_blank_lz=1, i_dp=4'b0010 -> digit0=F8, digit1=7F (blank with dp), digits2,3=FF. Then i_blank_lz=0 -> digits1..3 show C0, with digit1=40.
- Overflow: load 10000 -> after completion o_overflow=1 and all digits BF. Load 9999 -> o_overflow=0 and all digits 90.
- Ignored load / mid-op reset: load 42, pulse i_load with 99 on busy cycle 5 -> display 42. Load 555, assert i_reset on busy cycle 7 -> o_busy=0, display 0, outputs at reset values.
- Parametrisation: NUM_DIGITS=6, DATA_WIDTH=20, load 999999 -> six digits 90, o_busy 20 cycles. Load 1000000 -> overflow dashes.
